// File: rtl/motor_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : motor_scheduler
//  Description : Round-robin time-sharing of one 4-motor drive stage, with
//                fixed-length grant slices separated by LE-low dead time.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_scheduler #(
   parameter int unsigned SLICE = 8,
   parameter int unsigned GAP   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [15:0] vel,
   output logic        LE,
   output logic [1:0]  chave,
   output logic [3:0]  V,
   output logic [3:0]  grant,
   output logic        slice_done,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [7:0] C_SLICE_LOAD = 8'(SLICE - 1);
   localparam logic [3:0] C_GAP_LOAD   = 4'(GAP - 1);

   state_t      state_q;
   logic [1:0]  ptr_q;
   logic [7:0]  slice_cnt_q;
   logic [3:0]  gap_cnt_q;

   logic        arb_hit_d;
   logic [1:0]  arb_idx_d;
   logic [1:0]  cand_d;
   logic        arb_now_d;

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      arb_hit_d = 1'b0;
      arb_idx_d = ptr_q;
      cand_d    = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         cand_d = ptr_q + 2'(k);
         if (req[cand_d]) begin
            arb_hit_d = 1'b1;
            arb_idx_d = cand_d;
         end
      end
   end

   assign arb_now_d = (state_q == S_IDLE) || ((state_q == S_GAP) && (gap_cnt_q == 4'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= 2'd0;
         slice_cnt_q <= 8'd0;
         gap_cnt_q   <= 4'd0;
         LE          <= 1'b0;
         chave       <= 2'd0;
         V           <= 4'd0;
         grant       <= 4'd0;
         slice_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         slice_done <= 1'b0;
         if (arb_now_d) begin
            if (arb_hit_d) begin
               state_q     <= S_RUN;
               LE          <= 1'b1;
               chave       <= arb_idx_d;
               V           <= vel[{arb_idx_d, 2'b00} +: 4];
               grant       <= 4'b0001 << arb_idx_d;
               busy        <= 1'b1;
               slice_cnt_q <= C_SLICE_LOAD;
            end else begin
               state_q <= S_IDLE;
               LE      <= 1'b0;
               chave   <= 2'd0;
               V       <= 4'd0;
               grant   <= 4'd0;
               busy    <= 1'b0;
            end
         end else begin
            case (state_q)
               S_RUN: begin
                  // Counter expiry and requester release share one exit path.
                  if ((slice_cnt_q == 8'd0) || !req[chave]) begin
                     state_q    <= S_GAP;
                     LE         <= 1'b0;
                     V          <= 4'd0;
                     grant      <= 4'd0;
                     slice_done <= 1'b1;
                     ptr_q      <= chave + 2'd1;
                     gap_cnt_q  <= C_GAP_LOAD;
                  end else begin
                     slice_cnt_q <= slice_cnt_q - 8'd1;
                  end
               end
               S_GAP: begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_motor_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_scheduler
//  Description : Directed and randomized stimulus for motor_scheduler, checked
//                cycle by cycle against a slice-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_motor_scheduler;

   localparam int SLICE = 8;
   localparam int GAP   = 1;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] vel;
   logic        LE;
   logic [1:0]  chave;
   logic [3:0]  V;
   logic [3:0]  grant;
   logic        slice_done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   motor_scheduler #(.SLICE(SLICE), .GAP(GAP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .vel       (vel),
      .LE        (LE),
      .chave     (chave),
      .V         (V),
      .grant     (grant),
      .slice_done(slice_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 0 = idle, 1 = serving a motor, 2 = dead time.
   int          m_mode, m_owner, m_ptr, m_served, m_gapleft;
   logic [3:0]  m_v;
   logic        m_pulse;
   int          le_run;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_owner = 0; m_ptr = 0; m_served = 0; m_gapleft = 0;
      m_v = 4'd0; m_pulse = 1'b0; le_run = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [15:0] v);
      int w;
      m_pulse = 1'b0;
      if (m_mode == 0 || (m_mode == 2 && m_gapleft == 1)) begin
         w = pick(r, m_ptr);
         if (w >= 0) begin
            m_mode = 1; m_owner = w; m_served = 1; m_v = v[4*w +: 4];
         end else begin
            m_mode = 0;
         end
      end else if (m_mode == 2) begin
         m_gapleft--;
      end else if (m_served == SLICE || !r[m_owner]) begin
         m_mode = 2; m_gapleft = GAP; m_ptr = (m_owner + 1) % 4; m_pulse = 1'b1;
      end else begin
         m_served++;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("LE",         16'(LE),         16'(m_mode == 1));
      chk("grant",      16'(grant),      (m_mode == 1) ? 16'(4'b0001 << m_owner) : 16'd0);
      chk("chave",      16'(chave),      (m_mode == 0) ? 16'd0 : 16'(m_owner));
      chk("V",          16'(V),          (m_mode == 1) ? 16'(m_v) : 16'd0);
      chk("busy",       16'(busy),       16'(m_mode != 0));
      chk("slice_done", 16'(slice_done), 16'(m_pulse));
      le_run = LE ? le_run + 1 : 0;
      chk("le_run_bound", 16'(le_run <= SLICE), 16'd1);
   endtask

   task automatic step(input logic [3:0] r, input logic [15:0] v);
      req = r; vel = v;
      model_edge(r, v);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   int          starts[$];
   int          pulses;
   logic        prev_le;
   logic [3:0]  rr;
   logic [15:0] rv;

   initial begin
      rst_n = 1'b0; req = 4'd0; vel = 16'd0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Async reset while motor 2 is running.
      for (int i = 0; i < 4; i++) step(4'b0100, 16'h0700);
      chk("t1_pre_chave", 16'(chave), 16'd2);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, 16'h4321);
      chk("t1_first_grant", 16'(grant), 16'b0001);

      // Single requester, slice length and gap.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(4'b0100, 16'h0500);
         chk("t2_V", 16'(V), 16'd5);
      end
      step(4'b0100, 16'h0500);
      chk("t2_gap_le", 16'(LE), 16'd0);
      chk("t2_done", 16'(slice_done), 16'd1);
      step(4'b0100, 16'h0500);
      chk("t2_regrant_V", 16'(V), 16'd5);

      // Round-robin over all four motors.
      do_reset();
      pulses = 0; prev_le = 1'b0;
      for (int i = 0; i < 45; i++) begin
         step(4'b1111, 16'($urandom));
         if (LE && !prev_le) starts.push_back(int'(chave));
         if (slice_done) pulses++;
         prev_le = LE;
      end
      chk("t3_pulses", 16'(pulses), 16'd5);
      chk("t3_nstarts", 16'(starts.size()), 16'd5);
      for (int i = 0; i < starts.size() && i < 5; i++)
         chk("t3_seq", 16'(starts[i]), 16'(i % 4));

      // Early release by motor 1.
      do_reset();
      for (int i = 0; i < 4; i++) step(4'b0010, 16'h0030);
      step(4'b1000, 16'h0030);
      chk("t4_done", 16'(slice_done), 16'd1);
      step(4'b1010, 16'h6030);
      chk("t4_next", 16'(grant), 16'b1000);
      for (int i = 0; i < 9; i++) step(4'b1010, 16'h6030);
      chk("t4_then", 16'(grant), 16'b0010);

      // Speed latched at grant; zero speed still granted.
      do_reset();
      step(4'b0001, 16'h0009);
      for (int i = 0; i < 7; i++) begin
         step(4'b0001, 16'h0002);
         chk("t5_latched", 16'(V), 16'd9);
      end
      step(4'b0001, 16'h0002);
      step(4'b0001, 16'h0000);
      chk("t5_zero_V", 16'(V), 16'd0);
      chk("t5_zero_LE", 16'(LE), 16'd1);

      // No requesters -> idle, then a fresh request.
      for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000);
      chk("t6_idle_busy", 16'(busy), 16'd0);
      step(4'b1000, 16'h1000);
      chk("t6_grant", 16'(grant), 16'b1000);

      // Randomized traffic with occasional resets.
      rr = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
         rv = 16'($urandom);
         if ($urandom_range(0, 149) == 0) do_reset();
         else step(rr, rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
